adder_result_stage: RTL and testbench

Output stage placed directly downstream of `adder16`. It registers each sum `Z` and its five status flags (S, ZR, CY, P, V) into a 2-entry buffer with a valid/ready handshake, so the datapath after the adder can apply backpressure. It also keeps sticky carry and overflow indicators for software and, optionally, saturating event counters.

---
 rtl/adder_pkg.sv | 31 +++
 rtl/res_fifo2.sv | 66 ++++++
 rtl/adder_result_stage.sv | 111 +++++++++++
 tb/tb_adder_result_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder output path: flag bit positions, flag type, buffer depth.
package adder_pkg;

    localparam int FLAG_S  = 4;
    localparam int FLAG_ZR = 3;
    localparam int FLAG_CY = 2;
    localparam int FLAG_P  = 1;
    localparam int FLAG_V  = 0;

    localparam int RES_DEPTH = 2;

    typedef logic [4:0] adder_flags_t;

    function automatic adder_flags_t pack_flags(
        input logic s,
        input logic zr,
        input logic cy,
        input logic p,
        input logic v
    );
        adder_flags_t f;
        f          = '0;
        f[FLAG_S]  = s;
        f[FLAG_ZR] = zr;
        f[FLAG_CY] = cy;
        f[FLAG_P]  = p;
        f[FLAG_V]  = v;
        return f;
    endfunction

endpackage

// File: rtl/res_fifo2.sv
// Two-entry valid/ready FIFO holding storage, read/write pointers and occupancy.
module res_fifo2
    import adder_pkg::*;
#(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);

    logic [W-1:0] mem_q [RES_DEPTH];
    logic [W-1:0] mem_d [RES_DEPTH];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    // Ready is gated by reset so nothing can be pushed while the stage is held in reset.
    assign push_ready = rst_n && (cnt_q != 2'd2);
    assign pop_valid  = (cnt_q != 2'd0);
    assign pop_data   = mem_q[rd_ptr_q];

    assign push = push_valid && push_ready;
    assign pop  = pop_valid && pop_ready;

    always_comb begin
        for (int i = 0; i < RES_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/adder_result_stage.sv
// Registered output stage for adder16: 2-entry result buffer, sticky CY/V bits and,
// with ADDER_RES_STATS_EN defined, saturating CY/V event counters.
module adder_result_stage
    import adder_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_z,
    input  logic              in_s,
    input  logic              in_zr,
    input  logic              in_cy,
    input  logic              in_p,
    input  logic              in_v,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_z,
    output adder_flags_t      out_flags,
    output logic              sticky_cy,
    output logic              sticky_v,
`ifdef ADDER_RES_STATS_EN
    output logic [CNT_W-1:0]  cy_cnt,
    output logic [CNT_W-1:0]  ovf_cnt,
`endif
    input  logic              sticky_clr
);

    localparam int EW = DW + 5;

    logic [EW-1:0] push_data;
    logic [EW-1:0] pop_data;
    logic          push;
    logic [1:0]    event_vec;
    logic [1:0]    sticky_q, sticky_d;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign push_data = {in_z, pack_flags(in_s, in_zr, in_cy, in_p, in_v)};

    res_fifo2 #(
        .W (EW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (push_data),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (pop_data)
    );

    assign out_z     = pop_data[EW-1:5];
    assign out_flags = pop_data[4:0];

    assign push      = in_valid && in_ready;
    assign event_vec = {push && in_v, push && in_cy};

    genvar gi;
    // Index 0 tracks carry, index 1 tracks overflow; a push event beats a same-cycle clear.
    for (gi = 0; gi < 2; gi++) begin : g_sticky
        always_comb begin
            sticky_d[gi] = (sticky_q[gi] && !sticky_clr) || event_vec[gi];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sticky_q[gi] <= 1'b0;
            end else begin
                sticky_q[gi] <= sticky_d[gi];
            end
        end
    end

    assign sticky_cy = sticky_q[0];
    assign sticky_v  = sticky_q[1];

`ifdef ADDER_RES_STATS_EN
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    for (gi = 0; gi < 2; gi++) begin : g_cnt
        always_comb begin
            cnt_d[gi] = cnt_q[gi];
            if (sticky_clr) begin
                cnt_d[gi] = event_vec[gi] ? CNT_W'(1) : '0;
            end else if (event_vec[gi] && (cnt_q[gi] != '1)) begin
                cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q[gi] <= '0;
            end else begin
                cnt_q[gi] <= cnt_d[gi];
            end
        end
    end

    assign cy_cnt  = cnt_q[0];
    assign ovf_cnt = cnt_q[1];
`endif

endmodule

// File: tb/tb_adder_result_stage.sv
// Self-checking bench for adder_result_stage: queue-based reference model plus directed vectors.
module tb_adder_result_stage;

    localparam int DW    = 16;
    localparam int CNT_W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_z;
    logic [4:0]    in_f;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_z;
    logic [4:0]    out_flags;
    logic          sticky_cy, sticky_v;
    logic          sticky_clr;
`ifdef ADDER_RES_STATS_EN
    logic [CNT_W-1:0] cy_cnt, ovf_cnt;
    logic             s_in_ready, s_out_valid, s_sticky_cy, s_sticky_v;
    logic [DW-1:0]    s_out_z;
    logic [4:0]       s_out_flags;
    logic [1:0]       s_cy_cnt, s_ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    always #5 clk = ~clk;

    adder_result_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
        .in_s(in_f[4]), .in_zr(in_f[3]), .in_cy(in_f[2]), .in_p(in_f[1]), .in_v(in_f[0]),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags),
        .sticky_cy(sticky_cy), .sticky_v(sticky_v),
`ifdef ADDER_RES_STATS_EN
        .cy_cnt(cy_cnt), .ovf_cnt(ovf_cnt),
`endif
        .sticky_clr(sticky_clr)
    );

`ifdef ADDER_RES_STATS_EN
    adder_result_stage #(.DW(DW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_z(in_z),
        .in_s(in_f[4]), .in_zr(in_f[3]), .in_cy(in_f[2]), .in_p(in_f[1]), .in_v(in_f[0]),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_z(s_out_z), .out_flags(s_out_flags),
        .sticky_cy(s_sticky_cy), .sticky_v(s_sticky_v),
        .cy_cnt(s_cy_cnt), .ovf_cnt(s_ovf_cnt),
        .sticky_clr(sticky_clr)
    );
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a queue of {z, flags}, sticky bits and plain integer counters.
    logic [20:0] mq[$];
    bit          m_scy, m_sv;
    int          m_cyc, m_ovc;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    always @(posedge clk) begin
        bit do_push, do_pop;
        if (!rst_n) begin
            mq.delete();
            m_scy = 0; m_sv = 0; m_cyc = 0; m_ovc = 0;
        end else begin
            do_push = in_valid && (mq.size() < 2);
            do_pop  = (mq.size() > 0) && out_ready;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({in_z, in_f});
            m_scy = (m_scy && !sticky_clr) || (do_push && in_f[2]);
            m_sv  = (m_sv  && !sticky_clr) || (do_push && in_f[0]);
            if (sticky_clr) m_cyc = (do_push && in_f[2]) ? 1 : 0;
            else if (do_push && in_f[2] && m_cyc < CNT_MAX) m_cyc++;
            if (sticky_clr) m_ovc = (do_push && in_f[0]) ? 1 : 0;
            else if (do_push && in_f[0] && m_ovc < CNT_MAX) m_ovc++;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("mon_in_ready", 32'(in_ready), 32'(rst_n && (mq.size() < 2)));
            if (mq.size() != 0) begin
                check("mon_out_z", 32'(out_z), 32'(mq[0][20:5]));
                check("mon_out_flags", 32'(out_flags), 32'(mq[0][4:0]));
            end
            check("mon_sticky_cy", 32'(sticky_cy), 32'(m_scy));
            check("mon_sticky_v", 32'(sticky_v), 32'(m_sv));
`ifdef ADDER_RES_STATS_EN
            check("mon_cy_cnt", 32'(cy_cnt), 32'(m_cyc));
            check("mon_ovf_cnt", 32'(ovf_cnt), 32'(m_ovc));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] z, input logic [4:0] f);
        in_valid = v;
        in_z     = z;
        in_f     = f;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_z = '0; in_f = '0; out_ready = 0; sticky_clr = 0;
        cyc(); cyc();
        mon_en = 1;
        at_neg();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_z", 32'(out_z), 32'd0);
        check("reset_out_flags", 32'(out_flags), 32'd0);
        check("reset_sticky", {30'd0, sticky_cy, sticky_v}, 32'd0);

        cyc();
        rst_n = 1;
        at_neg();
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Single push with CY and V set
        cyc();
        out_ready = 1;
        drive(1, 16'h0fff, 5'b00101);
        cyc();
        drive(0, 16'h0, 5'b0);
        at_neg();
        $display("txn single_push z=%h flags=%b", out_z, out_flags);
        check("single_z", 32'(out_z), 32'h0fff);
        check("single_flags", 32'(out_flags), 32'b00101);
        check("single_sticky", {30'd0, sticky_cy, sticky_v}, 32'b11);

        cyc();
        sticky_clr = 1;
        cyc();
        sticky_clr = 0;
        at_neg();
        check("clr_sticky", {30'd0, sticky_cy, sticky_v}, 32'b00);

        // Backpressure
        cyc();
        out_ready = 0;
        drive(1, 16'h0000, 5'b01000);
        cyc();
        drive(1, 16'hffff, 5'b10000);
        cyc();
        drive(1, 16'h1234, 5'b00000);
        at_neg();
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head", 32'(out_z), 32'h0000);
        cyc();
        drive(0, 16'h0, 5'b0);
        at_neg();
        check("bp_hold_z", 32'(out_z), 32'h0000);
        check("bp_hold_flags", 32'(out_flags), 32'b01000);
        cyc();
        out_ready = 1;
        cyc();
        at_neg();
        $display("txn bp_pop2 z=%h flags=%b", out_z, out_flags);
        check("bp_second", 32'(out_z), 32'hffff);
        check("bp_second_flags", 32'(out_flags), 32'b10000);
        cyc();
        at_neg();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Simultaneous push/pop at occupancy 1
        cyc();
        out_ready = 0;
        drive(1, 16'h00AA, 5'b00010);
        cyc();
        out_ready = 1;
        drive(1, 16'h00BB, 5'b00000);
        cyc();
        drive(0, 16'h0, 5'b0);
        at_neg();
        $display("txn pushpop z=%h valid=%b", out_z, out_valid);
        check("pp_valid", 32'(out_valid), 32'd1);
        check("pp_head", 32'(out_z), 32'h00BB);
        check("pp_in_ready", 32'(in_ready), 32'd1);
        cyc();
        at_neg();
        check("pp_drained", 32'(out_valid), 32'd0);

        // Clear priority
        cyc();
        sticky_clr = 1;
        drive(1, 16'h8000, 5'b00001);
        cyc();
        sticky_clr = 0;
        drive(0, 16'h0, 5'b0);
        at_neg();
        check("clrpri_sticky_v", 32'(sticky_v), 32'd1);
        cyc();
        sticky_clr = 1;
        cyc();
        sticky_clr = 0;
        at_neg();
        check("clr_only_sticky_v", 32'(sticky_v), 32'd0);

        // Mid-stream reset with two entries buffered
        cyc();
        out_ready = 0;
        drive(1, 16'h1111, 5'b00100);
        cyc();
        drive(1, 16'h2222, 5'b00001);
        cyc();
        rst_n = 0;
        drive(1, 16'h3333, 5'b00101);
        at_neg();
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        cyc();
        at_neg();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sticky", {30'd0, sticky_cy, sticky_v}, 32'd0);
        cyc();
        rst_n = 1;
        drive(0, 16'h0, 5'b0);
        out_ready = 1;
        cyc();
        at_neg();
        check("rst_release_in_ready", 32'(in_ready), 32'd1);
        check("rst_no_stale", 32'(out_valid), 32'd0);

`ifdef ADDER_RES_STATS_EN
        cyc();
        sticky_clr = 1;
        cyc();
        sticky_clr = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'(i), 5'b00100);
            cyc();
        end
        drive(0, 16'h0, 5'b0);
        at_neg();
        check("cnt_three", 32'(cy_cnt), 32'd3);
        check("cnt_sat_three", 32'(s_cy_cnt), 32'd3);
        cyc();
        for (int i = 0; i < 2; i++) begin
            drive(1, 16'(i), 5'b00100);
            cyc();
        end
        drive(0, 16'h0, 5'b0);
        at_neg();
        $display("txn counters cy_cnt=%0d sat=%0d", cy_cnt, s_cy_cnt);
        check("cnt_five", 32'(cy_cnt), 32'd5);
        check("cnt_saturated", 32'(s_cy_cnt), 32'd3);
`endif

        cyc();
        cyc();
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
